// File: rtl/control_store_sequencer.sv
// Microaddress sequencer: INC/JMP/BRC/CALL/RET/RESTART with a LIFO return stack.
// New address appears one cycle after the op; SEQ_ACK_InLow=1 freezes everything except error clear.
module control_store_sequencer #(
  parameter int unsigned CSAI_DATAWIDTH = 11,
  parameter int unsigned STACK_DEPTH    = 4,
  parameter int unsigned RESET_VECTOR   = 0
) (
  input  logic                      ADDRESS_INCREMENTER_CLOCK_50,
  input  logic                      ADDRESS_INCREMENTER_RESET_InHigh,
  input  logic                      SEQ_ACK_InLow,
  input  logic [2:0]                SEQ_OP_InBus,
  input  logic [CSAI_DATAWIDTH-1:0] SEQ_BranchAddr_InBus,
  input  logic                      SEQ_Cond_In,
  input  logic                      SEQ_ClrErr_In,
  output logic [CSAI_DATAWIDTH-1:0] SEQ_Address_OutBus,
  output logic                      SEQ_StackEmpty_Out,
  output logic                      SEQ_StackFull_Out,
  output logic                      SEQ_Overflow_Out,
  output logic                      SEQ_Underflow_Out
);

  localparam int unsigned PW = $clog2(STACK_DEPTH + 1);
  localparam int unsigned IW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [CSAI_DATAWIDTH-1:0] RST_ADDR = CSAI_DATAWIDTH'(RESET_VECTOR);
  localparam logic [PW-1:0] SP_FULL = PW'(STACK_DEPTH);

  localparam logic [2:0] OP_JMP     = 3'b001;
  localparam logic [2:0] OP_BRC     = 3'b010;
  localparam logic [2:0] OP_CALL    = 3'b011;
  localparam logic [2:0] OP_RET     = 3'b100;
  localparam logic [2:0] OP_RESTART = 3'b101;

  logic [CSAI_DATAWIDTH-1:0] addr_q, addr_d, addr_inc;
  logic [PW-1:0]             sp_q, sp_d;
  logic [CSAI_DATAWIDTH-1:0] stack_q [STACK_DEPTH];
  logic [CSAI_DATAWIDTH-1:0] stack_d [STACK_DEPTH];
  logic                      ovf_q, ovf_d, unf_q, unf_d;
  logic                      ovf_set, unf_set;
  logic                      stack_empty, stack_full;
  logic [IW-1:0]             wr_idx, rd_idx;

  assign stack_empty = (sp_q == '0);
  assign stack_full  = (sp_q == SP_FULL);
  // sp_q points at the next free slot; the top entry sits one below it.
  assign wr_idx      = IW'(sp_q);
  assign rd_idx      = IW'(sp_q - PW'(1));
  assign addr_inc    = addr_q + CSAI_DATAWIDTH'(1);

  always_comb begin
    addr_d  = addr_q;
    sp_d    = sp_q;
    stack_d = stack_q;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    if (!SEQ_ACK_InLow) begin
      case (SEQ_OP_InBus)
        OP_JMP:  addr_d = SEQ_BranchAddr_InBus;
        OP_BRC:  addr_d = SEQ_Cond_In ? SEQ_BranchAddr_InBus : addr_inc;
        OP_CALL: begin
          if (stack_full) begin
            addr_d  = addr_inc;
            ovf_set = 1'b1;
          end else begin
            stack_d[wr_idx] = addr_inc;
            sp_d            = sp_q + PW'(1);
            addr_d          = SEQ_BranchAddr_InBus;
          end
        end
        OP_RET: begin
          if (stack_empty) begin
            addr_d  = addr_inc;
            unf_set = 1'b1;
          end else begin
            addr_d = stack_q[rd_idx];
            sp_d   = sp_q - PW'(1);
          end
        end
        OP_RESTART: begin
          addr_d = RST_ADDR;
          sp_d   = '0;
        end
        default: addr_d = addr_inc;
      endcase
    end
    // A new error in the same cycle as a clear leaves the flag set.
    ovf_d = ovf_set | (ovf_q & ~SEQ_ClrErr_In);
    unf_d = unf_set | (unf_q & ~SEQ_ClrErr_In);
  end

  always_ff @(posedge ADDRESS_INCREMENTER_CLOCK_50 or posedge ADDRESS_INCREMENTER_RESET_InHigh) begin
    if (ADDRESS_INCREMENTER_RESET_InHigh) begin
      addr_q <= RST_ADDR;
      sp_q   <= '0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
    end else begin
      addr_q <= addr_d;
      sp_q   <= sp_d;
      ovf_q  <= ovf_d;
      unf_q  <= unf_d;
    end
  end

  always_ff @(posedge ADDRESS_INCREMENTER_CLOCK_50) begin
    stack_q <= stack_d;
  end

  assign SEQ_Address_OutBus = addr_q;
  assign SEQ_StackEmpty_Out = stack_empty;
  assign SEQ_StackFull_Out  = stack_full;
  assign SEQ_Overflow_Out   = ovf_q;
  assign SEQ_Underflow_Out  = unf_q;

endmodule
